// File: rtl/dr_mem_ctrl_pkg.sv
// Shared types and rail helpers for the dual-rail memory controller.
// Optional code-error detection is built when DR_MEM_ERR_EN is defined.
package dr_pkg;

    typedef logic [1:0] dr_pair_t;

    localparam dr_pair_t DR_NULL = 2'b00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_OUT = 2'd1,
        RTZ    = 2'd2
    } dr_state_t;

    function automatic dr_pair_t dr_encode(input logic b);
        return {b, ~b};
    endfunction

    function automatic logic dr_decode(input dr_pair_t p);
        return p[1];
    endfunction

endpackage

// File: rtl/dr_mem_ctrl_if.sv
// Dual-rail requester/consumer bus seen by the memory controller.
interface dr_mem_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_data;
    logic [1:0]          req_op;
    logic                req_ack;
    logic [2*DATA_W-1:0] rd_data;
    logic                rd_ack_in;
    logic                err;

    modport master (
        output req_addr, req_data, req_op, rd_ack_in,
        input  req_ack, rd_data, err
    );

    modport slave (
        input  req_addr, req_data, req_op, rd_ack_in,
        output req_ack, rd_data, err
    );
endinterface

// File: rtl/dr_mem_ctrl_completion_det.sv
// Completion / null / illegal-code detector for an N-pair dual-rail bus.
module dr_completion_det
    import dr_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [2*N-1:0] bus,
    output logic           complete,
    output logic           is_null,
    output logic           illegal
);

    dr_pair_t pair_s;

    // Fold every rail pair into the three bus-wide flags
    always_comb begin
        complete = 1'b1;
        is_null  = 1'b1;
        illegal  = 1'b0;
        pair_s   = DR_NULL;
        for (int i = 0; i < N; i++) begin
            pair_s   = bus[2*i +: 2];
            complete = complete & (pair_s[1] ^ pair_s[0]);
            is_null  = is_null & (pair_s == DR_NULL);
            illegal  = illegal | (&pair_s);
        end
    end

endmodule

// File: rtl/dr_mem_ctrl.sv
// Clocked dual-rail memory with 4-phase return-to-zero handshake.
// Define DR_MEM_ERR_EN to build the sticky illegal-code flag.
module dr_mem_ctrl
    import dr_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    dr_mem_ctrl_if.slave  bus
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic addr_complete_s, addr_null_s, addr_illegal_s;
    logic data_complete_s, data_null_s, data_illegal_s;
    logic op_write_s, op_read_s, op_illegal_s, illegal_s;
    logic req_complete_s, req_null_s, in_range_s, mem_we_s;
    logic [ADDR_W-1:0]   addr_bin_s;
    logic [DATA_W-1:0]   wr_word_s, rd_word_s;
    logic [2*DATA_W-1:0] rd_enc_s;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    dr_state_t           state_r, state_s;
    logic                req_ack_r, req_ack_s;
    logic [2*DATA_W-1:0] rd_data_r, rd_data_s;

    dr_completion_det #(.N(ADDR_W)) u_addr_det (
        .bus      (bus.req_addr),
        .complete (addr_complete_s),
        .is_null  (addr_null_s),
        .illegal  (addr_illegal_s)
    );

    dr_completion_det #(.N(DATA_W)) u_data_det (
        .bus      (bus.req_data),
        .complete (data_complete_s),
        .is_null  (data_null_s),
        .illegal  (data_illegal_s)
    );

    assign op_write_s   = (bus.req_op == 2'b01);
    assign op_read_s    = (bus.req_op == 2'b10);
    assign op_illegal_s = (bus.req_op == 2'b11);
    // A both-rails-high code anywhere blocks the access, even on the unused data bus of a read
    assign illegal_s    = addr_illegal_s | data_illegal_s | op_illegal_s;
    assign req_complete_s = (op_write_s | op_read_s) & addr_complete_s
                          & (op_read_s | data_complete_s) & ~illegal_s;
    assign req_null_s   = addr_null_s & data_null_s & (bus.req_op == 2'b00);
    assign in_range_s   = ({1'b0, addr_bin_s} < DEPTH_L);

    // Rail decode of the request and encode of the stored word
    always_comb begin
        addr_bin_s = {ADDR_W{1'b0}};
        wr_word_s  = {DATA_W{1'b0}};
        rd_enc_s   = {2*DATA_W{1'b0}};
        for (int i = 0; i < ADDR_W; i++) begin
            addr_bin_s[i] = dr_decode(bus.req_addr[2*i +: 2]);
        end
        for (int i = 0; i < DATA_W; i++) begin
            wr_word_s[i] = dr_decode(bus.req_data[2*i +: 2]);
        end
        if (in_range_s) begin
            rd_word_s = mem_r[addr_bin_s];
        end else begin
            rd_word_s = {DATA_W{1'b0}};
        end
        for (int i = 0; i < DATA_W; i++) begin
            rd_enc_s[2*i +: 2] = dr_encode(rd_word_s[i]);
        end
    end

    // Storage write port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_s && !rst) begin
            mem_r[addr_bin_s] <= wr_word_s;
        end
    end

    // Handshake sequencing: next state and next registered outputs
    always_comb begin
        state_s   = state_r;
        req_ack_s = req_ack_r;
        rd_data_s = rd_data_r;
        mem_we_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_complete_s && op_write_s) begin
                    mem_we_s  = in_range_s;
                    req_ack_s = 1'b1;
                    state_s   = RTZ;
                end else if (req_complete_s && !bus.rd_ack_in) begin
                    rd_data_s = rd_enc_s;
                    state_s   = RD_OUT;
                end else begin
                    state_s   = IDLE;
                end
            end
            RD_OUT: begin
                if (bus.rd_ack_in) begin
                    rd_data_s = {2*DATA_W{1'b0}};
                    req_ack_s = 1'b1;
                    state_s   = RTZ;
                end else begin
                    state_s   = RD_OUT;
                end
            end
            RTZ: begin
                if (req_null_s && !bus.rd_ack_in) begin
                    req_ack_s = 1'b0;
                    state_s   = IDLE;
                end else begin
                    state_s   = RTZ;
                end
            end
            default: begin
                state_s   = IDLE;
                req_ack_s = 1'b0;
                rd_data_s = {2*DATA_W{1'b0}};
            end
        endcase
    end

    // State and handshake output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            req_ack_r <= 1'b0;
            rd_data_r <= {2*DATA_W{1'b0}};
        end else begin
            state_r   <= state_s;
            req_ack_r <= req_ack_s;
            rd_data_r <= rd_data_s;
        end
    end

    assign bus.req_ack = req_ack_r;
    assign bus.rd_data = rd_data_r;

`ifdef DR_MEM_ERR_EN
    logic err_r;

    // Sticky code-error flag, armed only while waiting for a request
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (state_r == IDLE && illegal_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign bus.err = err_r;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_dr_mem_ctrl.sv
// Directed scoreboard bench for dr_mem_ctrl (DEPTH=12 to expose out-of-range addresses).
module tb_dr_mem_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 12;
`ifdef DR_MEM_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks_total  = 0;
    int   checks_passed = 0;
    logic [DATA_W-1:0]   model_mem [16];
    logic [2*DATA_W-1:0] exp_q [$];

    dr_mem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dr_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [2*DATA_W-1:0] enc8(input logic [DATA_W-1:0] w);
        logic [2*DATA_W-1:0] r;
        for (int b = 0; b < DATA_W; b++) r[2*b +: 2] = {w[b], ~w[b]};
        return r;
    endfunction

    function automatic logic [2*ADDR_W-1:0] enc4(input logic [ADDR_W-1:0] a);
        logic [2*ADDR_W-1:0] r;
        for (int b = 0; b < ADDR_W; b++) r[2*b +: 2] = {a[b], ~a[b]};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) begin
            checks_passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv_null();
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.req_op   = 2'b00;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.req_addr = enc4(a);
        bus.req_data = enc8(d);
        bus.req_op   = 2'b01;
        if (int'(a) < DEPTH) model_mem[a] = d;
        chk("wr_ack_before_edge", bus.req_ack, 1'b0);
        tick();
        chk("wr_ack_rise", bus.req_ack, 1'b1);
        drv_null();
        tick();
        chk("wr_ack_fall", bus.req_ack, 1'b0);
    endtask

    task automatic rd_req(input logic [ADDR_W-1:0] a);
        bus.req_addr = enc4(a);
        bus.req_data = '0;
        bus.req_op   = 2'b10;
        if (int'(a) < DEPTH) exp_q.push_back(enc8(model_mem[a]));
        else exp_q.push_back(enc8(8'h00));
    endtask

    task automatic wait_rd(input string tag, input int exp_lat);
        int lat = 0;
        logic [2*DATA_W-1:0] exp;
        do begin
            tick();
            lat++;
        end while (bus.rd_data === '0 && lat < 8);
        chk({tag, "_latency"}, lat, exp_lat);
        exp = exp_q.pop_front();
        chk({tag, "_data"}, bus.rd_data, exp);
        chk({tag, "_ack_low"}, bus.req_ack, 1'b0);
    endtask

    task automatic rd_finish(input string tag);
        bus.rd_ack_in = 1'b1;
        tick();
        chk({tag, "_rd_null"}, bus.rd_data, 16'h0000);
        chk({tag, "_ack_rise"}, bus.req_ack, 1'b1);
        drv_null();
        bus.rd_ack_in = 1'b0;
        tick();
        chk({tag, "_ack_fall"}, bus.req_ack, 1'b0);
    endtask

    task automatic rd_full(input string tag, input logic [ADDR_W-1:0] a);
        rd_req(a);
        wait_rd(tag, 1);
        rd_finish(tag);
    endtask

    initial begin
        logic [2*ADDR_W-1:0] a_full;
        logic [2*ADDR_W-1:0] a_cur;

        rst = 1'b1;
        bus.rd_ack_in = 1'b0;
        drv_null();
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("reset_ack", bus.req_ack, 1'b0);
        chk("reset_rd_data", bus.rd_data, 16'h0000);
        chk("reset_err", bus.err, 1'b0);

        // Write then read back; known encoding of 0xA5
        wr(4'd3, 8'hA5);
        rd_req(4'd3);
        wait_rd("rd_a5", 1);
        chk("rd_a5_literal", bus.rd_data, 16'b1001100101100110);
        rd_finish("rd_a5");

        // Address pairs arriving one per cycle
        wr(4'd1, 8'h11);
        a_full = enc4(4'd5);
        a_cur  = '0;
        bus.req_data = enc8(8'h3C);
        bus.req_op   = 2'b01;
        for (int i = 0; i < ADDR_W; i++) begin
            a_cur[2*i +: 2] = a_full[2*i +: 2];
            bus.req_addr = a_cur;
            tick();
            chk("partial_addr_ack", bus.req_ack, (i == ADDR_W - 1) ? 1'b1 : 1'b0);
        end
        model_mem[5] = 8'h3C;
        drv_null();
        tick();
        chk("partial_ack_fall", bus.req_ack, 1'b0);
        rd_full("rd_partial", 4'd5);
        rd_full("rd_untouched", 4'd1);

        // Read held off while the consumer is still acknowledging
        bus.rd_ack_in = 1'b1;
        rd_req(4'd3);
        tick();
        chk("held_rd_null", bus.rd_data, 16'h0000);
        chk("held_ack", bus.req_ack, 1'b0);
        tick();
        chk("held_rd_null2", bus.rd_data, 16'h0000);
        bus.rd_ack_in = 1'b0;
        wait_rd("rd_held", 1);
        rd_finish("rd_held");

        // Depth boundary and out-of-range addresses
        wr(4'd11, 8'h5A);
        rd_full("rd_last", 4'd11);
        wr(4'd13, 8'hFF);
        rd_full("rd_oor", 4'd13);

        // Reset during RD_OUT aborts the read, memory kept
        rd_req(4'd3);
        wait_rd("rd_abort", 1);
        rst = 1'b1;
        drv_null();
        tick();
        chk("abort_rd_null", bus.rd_data, 16'h0000);
        chk("abort_ack", bus.req_ack, 1'b0);
        rst = 1'b0;
        tick();
        rd_full("rd_after_rst", 4'd3);

        // Illegal code on address pair 0
        bus.req_addr = enc4(4'd3) | 8'b0000_0011;
        bus.req_data = enc8(8'h00);
        bus.req_op   = 2'b01;
        tick();
        chk("illegal_err", bus.err, EXP_ERR);
        chk("illegal_no_ack", bus.req_ack, 1'b0);
        tick();
        chk("illegal_no_ack2", bus.req_ack, 1'b0);
        drv_null();
        tick();
        chk("illegal_err_sticky", bus.err, EXP_ERR);
        rd_full("rd_after_illegal", 4'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("err_cleared", bus.err, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
